// File: rtl/fanin_pkg.sv
// Shared constants and index helpers for the child-to-root fan-in blocks.
// Pure definitions: no latency, no flow control.
// Imported by the arbiter and the collector top.
package fanin_pkg;

  localparam int NUM_CHILD_DEF = 5;
  localparam int DATA_W_DEF    = 16;

  // Wrap-around increment over 0..n-1.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first requester at or after ptr, wrapping.
// Combinational, zero latency.
// No flow control of its own; the caller decides whether a grant is taken.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int   cand;
  logic found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_idx          = IDX_W'(cand);
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fanin_collector.sv
// Round-robin fan-in of child streams into one registered output word plus source index.
// Latency: 1 cycle from input accept to out_*; sustains 1 word/cycle.
// Backpressure: in_ready is zero whenever the output register is full and not being drained.
module fanin_collector
  import fanin_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SRC_W     = $clog2(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        in_valid,
  output logic [NUM_CHILD-1:0]        in_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  output logic [15:0]                 xfer_cnt
);

  logic [SRC_W-1:0]     ptr;
  logic [SRC_W-1:0]     gnt_idx;
  logic [NUM_CHILD-1:0] gnt_onehot;
  logic                 any_req;
  logic                 free;
  logic                 in_xfer;
  logic [DATA_W-1:0]    gnt_data;

  rr_arbiter #(
    .N     (NUM_CHILD),
    .IDX_W (SRC_W)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  assign free     = !out_valid || out_ready;
  // Reset also masks ready so no child sees a handshake that is then dropped.
  assign in_xfer  = free && any_req && !rst;
  assign in_ready = in_xfer ? gnt_onehot : '0;
  assign gnt_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_src   <= gnt_idx;
      ptr       <= SRC_W'(next_idx(int'(gnt_idx), NUM_CHILD));
      xfer_cnt  <= xfer_cnt + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fanin_collector.sv
// Bench for fanin_collector: directed scenarios plus randomized traffic
// checked against a transaction-level model of the collector.
module tb_fanin_collector;

  localparam int NC = 5;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [NC-1:0] in_valid;
  logic [NC-1:0] in_ready;
  logic [NC*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_src;
  logic [15:0]   xfer_cnt;

  int checks;
  int failures;

  // Model state: what the root should currently be seeing.
  int          m_ptr;
  logic        m_ov;
  logic [15:0] m_data;
  int          m_src;
  logic [15:0] m_cnt;

  fanin_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 0; k < NC; k++) begin
      if (in_valid[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] model_rdy();
    int g;
    logic [NC-1:0] r;
    r = '0;
    g = model_grant();
    if (!rst && g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // One clock: decide the transaction from current inputs, clock the DUT, update the model.
  task automatic tick();
    int g;
    int gs;
    logic take;
    logic drain;
    logic [15:0] d;
    g     = model_grant();
    gs    = (g < 0) ? 0 : g;
    take  = (g >= 0) && (!m_ov || out_ready);
    drain = m_ov && out_ready;
    d     = in_data[gs*DW +: DW];
    @(posedge clk);
    if (rst) begin
      m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = '0;
    end else if (take) begin
      m_ov = 1'b1; m_data = d; m_src = g; m_ptr = (g + 1) % NC; m_cnt = m_cnt + 16'd1;
    end else if (drain) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = 16'h2000 + 16'(i);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (in_ready !== 5'b00000) begin
        failures++; $display("FAIL reset_in_ready: got %b expected 00000", in_ready);
      end
      checks++;
      if ({out_valid, out_data, out_src, xfer_cnt} !== {1'b0, 16'h0, 3'd0, 16'h0}) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b d=%h s=%0d cnt=%h expected 0 0000 0 0000",
                 out_valid, out_data, out_src, xfer_cnt);
      end
      checks++;
      if (dut.ptr !== 3'd0) begin
        failures++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 5'b00001) begin
      failures++; $display("FAIL reset_first_ready: got %b expected 00001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 16'h2000}) begin
      failures++;
      $display("FAIL reset_first_grant: got v=%b s=%0d d=%h expected 1 0 2000", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = 16'h1000 + 16'(i);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, 3'(k % NC), 16'h1000 + 16'(k % NC)}) begin
        failures++;
        $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h expected 1 %0d %h",
                 k, out_valid, out_src, out_data, k % NC, 16'h1000 + 16'(k % NC));
      end
    end
    checks++;
    if (xfer_cnt !== 16'd6) begin
      failures++; $display("FAIL rr_count: got %0d expected 6", xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data = '0;
    in_data[2*DW +: DW] = 16'hAAAA;
    in_data[0*DW +: DW] = 16'h5555;
    in_valid = 5'b00100; out_ready = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd2, 16'hAAAA}) begin
      failures++;
      $display("FAIL bp_load: got v=%b s=%0d d=%h expected 1 2 aaaa", out_valid, out_src, out_data);
    end
    in_valid = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 5'b00000) begin
        failures++; $display("FAIL bp_stall_ready[%0d]: got %b expected 00000", c, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_src, out_data, dut.ptr} !== {1'b1, 3'd2, 16'hAAAA, 3'd3}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h ptr=%0d expected 1 2 aaaa 3",
                 c, out_valid, out_src, out_data, dut.ptr);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 5'b00001) begin
      failures++; $display("FAIL bp_release_ready: got %b expected 00001", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 3'd0, 16'h5555}) begin
      failures++;
      $display("FAIL bp_reload: got v=%b s=%0d d=%h expected 1 0 5555", out_valid, out_src, out_data);
    end
    in_valid = '0;
    tick();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b0, 3'd0, 16'h5555}) begin
      failures++;
      $display("FAIL bp_drain: got v=%b s=%0d d=%h expected 0 0 5555", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = 16'h3000 + 16'(i);
    in_valid = 5'b01000;
    tick();
    checks++;
    if (dut.ptr !== 3'd4) begin
      failures++; $display("FAIL sparse_setup_ptr: got %0d expected 4", dut.ptr);
    end
    tick();
    checks++;
    if ({out_src, out_data, dut.ptr} !== {3'd3, 16'h3003, 3'd4}) begin
      failures++;
      $display("FAIL sparse_c3: got s=%0d d=%h ptr=%0d expected 3 3003 4", out_src, out_data, dut.ptr);
    end
    in_valid = 5'b00010;
    tick();
    checks++;
    if ({out_src, out_data, dut.ptr} !== {3'd1, 16'h3001, 3'd2}) begin
      failures++;
      $display("FAIL sparse_c1: got s=%0d d=%h ptr=%0d expected 1 3001 2", out_src, out_data, dut.ptr);
    end
    in_valid = '0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if ({out_valid, dut.ptr} !== {1'b0, 3'd2}) begin
      failures++; $display("FAIL sparse_idle: got v=%b ptr=%0d expected 0 2", out_valid, dut.ptr);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_data[4*DW +: DW] = 16'hBEEF;
    in_valid = 5'b10000; out_ready = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL mid_load: got v=%b d=%h expected 1 beef", out_valid, out_data);
    end
    in_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, dut.ptr, out_data} !== {1'b0, 3'd0, 16'h0}) begin
      failures++;
      $display("FAIL mid_reset: got v=%b ptr=%0d d=%h expected 0 0 0000", out_valid, dut.ptr, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL mid_discard[%0d]: got v=%b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = NC'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = 16'($urandom);
      #1;
      checks++;
      if (in_ready !== model_rdy()) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, model_rdy());
      end
      tick();
      checks++;
      if ({out_valid, out_data, out_src, xfer_cnt, dut.ptr} !==
          {m_ov, m_data, 3'(m_src), m_cnt, 3'(m_ptr)}) begin
        failures++;
        $display("FAIL rand_state[%0d]: got v=%b d=%h s=%0d cnt=%h ptr=%0d expected %b %h %0d %h %0d",
                 c, out_valid, out_data, out_src, xfer_cnt, dut.ptr, m_ov, m_data, m_src, m_cnt, m_ptr);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 5'b11111; out_ready = 1'b1;
    for (int c = 0; c < 65534; c++) tick();
    checks++;
    if (xfer_cnt !== 16'hFFFE) begin
      failures++; $display("FAIL wrap_pre: got %h expected fffe", xfer_cnt);
    end
    tick();
    checks++;
    if (xfer_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_ffff: got %h expected ffff", xfer_cnt);
    end
    tick();
    checks++;
    if (xfer_cnt !== 16'h0000) begin
      failures++; $display("FAIL wrap_zero: got %h expected 0000", xfer_cnt);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; m_ov = 1'b0; m_data = '0; m_src = 0; m_cnt = '0;
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_midflight();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fanin_collector.md
# fanin_collector

Upstream fan-in block for a root module and its five child instances. Each child presents a valid/ready stream toward the root. The collector picks one stream per cycle by round-robin and registers the winning word with its source index in a single output stage. Children can only push words upward, so this block is the return path that complements the root-to-child instantiation fan-out.

## Interface
- `NUM_CHILD`, default 5: number of child streams; legal range 2..16.
- `DATA_W`, default 16: payload width per child.
- `SRC_W`, default `$clog2(NUM_CHILD)` (3): width of the source index.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, `NUM_CHILD`: per-child word valid.
- `in_ready`, output, `NUM_CHILD`: per-child accept; one-hot or zero.
- `in_data`, input, `NUM_CHILD*DATA_W`: child i occupies bits `[i*DATA_W +: DATA_W]`.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: root accepts the word.
- `out_data`, output, `DATA_W`: registered payload.
- `out_src`, output, `SRC_W`: index of the child that produced `out_data`.
- `xfer_cnt`, output, 16: count of words accepted from children; wraps.

## Operation
- Input transfer on child i: `in_valid[i] && in_ready[i]` at a rising edge.
- Output transfer: `out_valid && out_ready` at a rising edge.
- Priority pointer `ptr` (`SRC_W` bits) selects the highest-priority child. Priority order is `ptr, ptr+1, …, NUM_CHILD-1, 0, …, ptr-1`.
- Grant `g`: the first child in priority order with `in_valid` high. Grant is combinational from `in_valid` and `ptr`.
- Stage free: `free = !out_valid || out_ready`.
- `in_ready[g] = free && any(in_valid)`. All other `in_ready` bits are 0.
  - `in_ready` depends combinationally on `out_ready`. There is no path from `in_data` to `in_ready`.
- On an input transfer from g:
  - `out_data <= in_data[g]`, `out_src <= g`, `out_valid <= 1`.
  - `ptr <= (g == NUM_CHILD-1) ? 0 : g+1`.
  - `xfer_cnt <= xfer_cnt + 1`, wrapping 0xFFFF to 0x0000.
- Output transfer with no input transfer in the same cycle: `out_valid <= 0`. `out_data` and `out_src` hold their values.
- Output transfer and input transfer in the same cycle: the register is reloaded, `out_valid` stays 1. This gives one word per cycle sustained.
- `out_valid` high and `out_ready` low: all `in_ready` are 0. `out_data`, `out_src` and `ptr` hold.
- `ptr` changes only on an input transfer. Idle cycles never move it.
- Inputs with no `in_valid` high: no transfer, no state change except draining the output.

## Timing
- Reset: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, `xfer_cnt`=0, `in_ready`=0.
- `rst` asserted mid-transfer takes priority over every update. A word held in the register is discarded, not delivered.
- Latency: a word accepted at edge N is visible on `out_*` after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while `out_ready` is held high.
- Fairness: with all children valid continuously, grants rotate 0,1,2,3,4,0,… Each child waits at most `NUM_CHILD-1` grants.
- Children must hold `in_valid` and `in_data` stable until accepted. The block does not check this.

## Structure
- Shared package `fanin_pkg`: `NUM_CHILD_DEF`, `DATA_W_DEF`, and `function next_idx(idx, n)` for the wrap increment.
- Sub-module `rr_arbiter` (ports `req`, `ptr`, `gnt_onehot`, `gnt_idx`, `any`; purely combinational). Reused by later fan-in blocks.
- Top level holds the output register, `ptr`, `xfer_cnt` and handshake logic.

## Test plan
- Reset: assert `rst` for 2 cycles with all `in_valid`=5'b11111 → `in_ready`=0, `out_valid`=0, `xfer_cnt`=0 during reset. After release, the first grant goes to child 0.
- Round-robin: all children valid, data = 0x1000+i, `out_ready`=1 → `out_src` sequence 0,1,2,3,4,0 on consecutive cycles, `out_data` 0x1000..0x1004, `xfer_cnt`=6 after 6 transfers.
- Backpressure: `out_valid`=1 with word 0xAAAA, `out_ready`=0 for 3 cycles → `in_ready`=0, output stable. Raising `out_ready` gives a simultaneous reload in that cycle.
- Sparse request: only child 3 valid with `ptr`=4 → grant child 3, then `ptr`=4. Next, only child 1 valid → grant child 1, then `ptr`=2.
- Wrap: preload `xfer_cnt` to 0xFFFE via 65534 transfers, or force it → next two transfers give 0xFFFF then 0x0000.
- Reset mid-flight: `out_valid`=1, assert `rst` → next cycle `out_valid`=0, `ptr`=0, and the held word never appears.
